// File: rtl/axioma_pkg.sv
// Shared types for the axioma_cpu core: opcode classes produced by the
// decoder, the two-state run/halt FSM encoding, SREG bit positions and the
// decoded-instruction record passed from decoder to datapath.
package axioma_pkg;

  typedef enum logic [4:0] {
    OP_NOP, OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_OR, OP_EOR,
    OP_MOV, OP_CP, OP_CPC, OP_LDI, OP_CPI, OP_SUBI, OP_ANDI, OP_ORI,
    OP_RJMP, OP_BRBS, OP_BRBC, OP_LD, OP_ST, OP_BAD
  } op_e;

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  localparam int SREG_C = 0;
  localparam int SREG_Z = 1;
  localparam int SREG_N = 2;
  localparam int SREG_V = 3;
  localparam int SREG_S = 4;
  localparam int SREG_H = 5;
  localparam int SREG_T = 6;
  localparam int SREG_I = 7;

  typedef struct packed {
    op_e        op;
    logic [4:0] rd;    // destination / first operand
    logic [4:0] rr;    // second operand register (store source for ST)
    logic [7:0] imm;   // K for immediate forms
    logic [11:0] k12;  // RJMP offset
    logic [6:0] k7;    // branch offset
    logic [2:0] bsel;  // SREG bit tested by BRBS/BRBC
  } dec_t;

endpackage

// File: rtl/axioma_decoder.sv
// Pure combinational AVR-subset decoder.
//   instr                   : 16-bit instruction word
//   dec                     : decoded op class and operand fields
//   unsupported_instruction : high for any encoding outside the subset
module axioma_decoder
  import axioma_pkg::*;
(
  input  logic [15:0] instr,
  output dec_t        dec,
  output logic        unsupported_instruction
);

  always_comb begin
    dec.op   = OP_BAD;
    dec.rd   = {instr[8], instr[7:4]};
    dec.rr   = {instr[9], instr[3:0]};
    dec.imm  = {instr[11:8], instr[3:0]};
    dec.k12  = instr[11:0];
    dec.k7   = instr[9:3];
    dec.bsel = instr[2:0];
    casez (instr)
      16'b0000_0000_0000_0000: dec.op = OP_NOP;
      16'b0000_01??_????_????: dec.op = OP_CPC;
      16'b0000_10??_????_????: dec.op = OP_SBC;
      16'b0000_11??_????_????: dec.op = OP_ADD;
      16'b0001_01??_????_????: dec.op = OP_CP;
      16'b0001_10??_????_????: dec.op = OP_SUB;
      16'b0001_11??_????_????: dec.op = OP_ADC;
      16'b0010_00??_????_????: dec.op = OP_AND;
      16'b0010_01??_????_????: dec.op = OP_EOR;
      16'b0010_10??_????_????: dec.op = OP_OR;
      16'b0010_11??_????_????: dec.op = OP_MOV;
      16'b0011_????_????_????: dec.op = OP_CPI;
      16'b0101_????_????_????: dec.op = OP_SUBI;
      16'b0110_????_????_????: dec.op = OP_ORI;
      16'b0111_????_????_????: dec.op = OP_ANDI;
      16'b1100_????_????_????: dec.op = OP_RJMP;
      16'b1110_????_????_????: dec.op = OP_LDI;
      16'b1111_00??_????_????: dec.op = OP_BRBS;
      16'b1111_01??_????_????: dec.op = OP_BRBC;
      16'b1001_000?_????_1100: dec.op = OP_LD;
      16'b1001_001?_????_1100: dec.op = OP_ST;
      default:                 dec.op = OP_BAD;
    endcase
    // Immediate forms only reach the upper register half.
    if (dec.op inside {OP_LDI, OP_CPI, OP_SUBI, OP_ANDI, OP_ORI})
      dec.rd = {1'b1, instr[7:4]};
    // ST encodes its source register in the Rd field.
    if (dec.op == OP_ST)
      dec.rr = {instr[8], instr[7:4]};
    unsupported_instruction = (dec.op == OP_BAD);
  end

endmodule

// File: rtl/axioma_cpu.sv
// Single-cycle AVR-subset core with 32x8 register file, inline ALU and
// X-pointer LD/ST over a ready-handshaked data port.
//   clk, reset                     : clock, synchronous active-high reset
//   program_addr/data/ready        : instruction fetch (addr = PC)
//   data_addr/out/in/read/write/ready : data port used by LD/ST
//   cpu_halted, status_reg         : HALT indication, SREG
//   debug_pc/instruction/reg_r16/r17 : observation
module axioma_cpu
  import axioma_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] program_addr,
  input  logic [15:0] program_data,
  input  logic        program_ready,
  output logic [15:0] data_addr,
  output logic [7:0]  data_out,
  input  logic [7:0]  data_in,
  output logic        data_read,
  output logic        data_write,
  input  logic        data_ready,
  output logic        cpu_halted,
  output logic [7:0]  status_reg,
  output logic [15:0] debug_pc,
  output logic [15:0] debug_instruction,
  output logic [7:0]  debug_reg_r16,
  output logic [7:0]  debug_reg_r17
);

  state_e      state;
  logic [15:0] pc;
  logic [7:0]  sreg;
  logic [7:0]  rf [0:31];

  dec_t dec;
  logic unsupported;

  axioma_decoder decoder_inst (
    .instr                   (program_data),
    .dec                     (dec),
    .unsupported_instruction (unsupported)
  );

  logic [7:0]  a, b, res;
  logic        cin, we, done, rd_c, wr_c, active;
  logic [8:0]  sum9, dif9;
  logic [7:0]  sreg_n;
  logic [15:0] pc_n;

  assign active = (state == ST_RUN) && program_ready;

  always_comb begin
    a    = rf[dec.rd];
    b    = (dec.op inside {OP_LDI, OP_CPI, OP_SUBI, OP_ANDI, OP_ORI}) ? dec.imm : rf[dec.rr];
    cin  = (dec.op inside {OP_ADC, OP_SBC, OP_CPC}) ? sreg[SREG_C] : 1'b0;
    sum9 = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    dif9 = {1'b0, a} - {1'b0, b} - {8'd0, cin};
    res    = 8'h00;
    we     = 1'b0;
    done   = 1'b1;
    rd_c   = 1'b0;
    wr_c   = 1'b0;
    sreg_n = sreg;
    pc_n   = pc + 16'd1;
    case (dec.op)
      OP_ADD, OP_ADC: begin
        res = sum9[7:0];
        we  = 1'b1;
        sreg_n[SREG_C] = sum9[8];
        sreg_n[SREG_H] = (a[3] & b[3]) | (b[3] & ~res[3]) | (~res[3] & a[3]);
        sreg_n[SREG_V] = (a[7] == b[7]) && (res[7] != a[7]);
        sreg_n[SREG_N] = res[7];
        sreg_n[SREG_Z] = (res == 8'h00);
        sreg_n[SREG_S] = sreg_n[SREG_N] ^ sreg_n[SREG_V];
      end
      OP_SUB, OP_SBC, OP_SUBI, OP_CP, OP_CPC, OP_CPI: begin
        res = dif9[7:0];
        we  = dec.op inside {OP_SUB, OP_SBC, OP_SUBI};
        sreg_n[SREG_C] = dif9[8];
        sreg_n[SREG_H] = (~a[3] & b[3]) | (b[3] & res[3]) | (res[3] & ~a[3]);
        sreg_n[SREG_V] = (a[7] != b[7]) && (res[7] != a[7]);
        sreg_n[SREG_N] = res[7];
        // Carry-chained forms keep Z only if every byte so far was zero.
        sreg_n[SREG_Z] = (dec.op inside {OP_SBC, OP_CPC}) ? (sreg[SREG_Z] & (res == 8'h00))
                                                         : (res == 8'h00);
        sreg_n[SREG_S] = sreg_n[SREG_N] ^ sreg_n[SREG_V];
      end
      OP_AND, OP_ANDI, OP_OR, OP_ORI, OP_EOR: begin
        res = (dec.op inside {OP_AND, OP_ANDI}) ? (a & b) :
              (dec.op inside {OP_OR, OP_ORI})   ? (a | b) : (a ^ b);
        we  = 1'b1;
        sreg_n[SREG_V] = 1'b0;
        sreg_n[SREG_N] = res[7];
        sreg_n[SREG_Z] = (res == 8'h00);
        sreg_n[SREG_S] = res[7];
      end
      OP_MOV, OP_LDI: begin
        res = b;
        we  = 1'b1;
      end
      OP_RJMP: pc_n = pc + 16'd1 + {{4{dec.k12[11]}}, dec.k12};
      OP_BRBS: if (sreg[dec.bsel])  pc_n = pc + 16'd1 + {{9{dec.k7[6]}}, dec.k7};
      OP_BRBC: if (!sreg[dec.bsel]) pc_n = pc + 16'd1 + {{9{dec.k7[6]}}, dec.k7};
      OP_LD: begin
        rd_c = 1'b1;
        res  = data_in;
        we   = data_ready;
        done = data_ready;
      end
      OP_ST: begin
        wr_c = 1'b1;
        done = data_ready;
      end
      default: ;
    endcase
  end

  assign data_read  = active & rd_c;
  assign data_write = active & wr_c;
  assign data_addr  = (data_read || data_write) ? {rf[27], rf[26]} : 16'h0000;
  assign data_out   = data_write ? rf[dec.rr] : 8'h00;

  assign program_addr  = pc;
  assign debug_pc      = pc;
  assign status_reg    = sreg;
  assign debug_reg_r16 = rf[16];
  assign debug_reg_r17 = rf[17];

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_RUN;
      cpu_halted        <= 1'b0;
      pc                <= RESET_PC;
      sreg              <= 8'h00;
      debug_instruction <= 16'h0000;
      for (int i = 0; i < 32; i++) rf[i] <= 8'h00;
    end else begin
      case (state)
        ST_RUN: begin
          if (program_ready) begin
            if (unsupported) begin
              state      <= ST_HALT;
              cpu_halted <= 1'b1;
            end else if (done) begin
              pc                <= pc_n;
              sreg              <= sreg_n;
              debug_instruction <= program_data;
              if (we) rf[dec.rd] <= res;
            end
          end
        end
        ST_HALT: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axioma_cpu.sv
module tb_axioma_cpu;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] program_addr, program_data;
  logic        program_ready;
  logic [15:0] data_addr;
  logic [7:0]  data_out, data_in;
  logic        data_read, data_write, data_ready, cpu_halted;
  logic [7:0]  status_reg, debug_reg_r16, debug_reg_r17;
  logic [15:0] debug_pc, debug_instruction;

  axioma_cpu #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset),
    .program_addr(program_addr), .program_data(program_data), .program_ready(program_ready),
    .data_addr(data_addr), .data_out(data_out), .data_in(data_in),
    .data_read(data_read), .data_write(data_write), .data_ready(data_ready),
    .cpu_halted(cpu_halted), .status_reg(status_reg), .debug_pc(debug_pc),
    .debug_instruction(debug_instruction),
    .debug_reg_r16(debug_reg_r16), .debug_reg_r17(debug_reg_r17)
  );

  always #5 clk = ~clk;

  logic [15:0] prog [0:255];
  assign program_data = prog[program_addr[7:0]];

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] npc;
    logic [7:0]  r16, r17, sreg;
  } vec_t;

  vec_t tv [0:63];
  int   nv = 0;
  vec_t sb [$];
  int   passed = 0, total = 0;

  task automatic add(input logic [15:0] pc, input logic [15:0] instr, input logic [15:0] npc,
                     input logic [7:0] r16, input logic [7:0] r17, input logic [7:0] s);
    tv[nv] = '{pc, instr, npc, r16, r17, s};
    nv++;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t e;
    reset = 1'b1; program_ready = 1'b0; data_ready = 1'b1; data_in = 8'hA5;
    for (int i = 0; i < 256; i++) prog[i] = 16'h0000;

    //  pc     instr     next   r16    r17    sreg
    add(16'd0,  16'hE005, 16'd1,  8'h05, 8'h00, 8'h00); // LDI R16,5
    add(16'd1,  16'hE013, 16'd2,  8'h05, 8'h03, 8'h00); // LDI R17,3
    add(16'd2,  16'h0F01, 16'd3,  8'h08, 8'h03, 8'h00); // ADD
    add(16'd3,  16'h3008, 16'd4,  8'h08, 8'h03, 8'h02); // CPI R16,8
    add(16'd4,  16'hF009, 16'd6,  8'h08, 8'h03, 8'h02); // BREQ +1 taken
    add(16'd6,  16'hE010, 16'd7,  8'h08, 8'h00, 8'h02); // LDI R17,0
    add(16'd7,  16'h5011, 16'd8,  8'h08, 8'hFF, 8'h35); // SUBI R17,1
    add(16'd8,  16'h2700, 16'd9,  8'h00, 8'hFF, 8'h23); // EOR R16,R16
    add(16'd9,  16'h0F01, 16'd10, 8'hFF, 8'hFF, 8'h14); // ADD 00+FF
    add(16'd10, 16'hE011, 16'd11, 8'hFF, 8'h01, 8'h14); // LDI R17,1
    add(16'd11, 16'h0F01, 16'd12, 8'h00, 8'h01, 8'h23); // ADD FF+01
    add(16'd12, 16'h1F01, 16'd13, 8'h02, 8'h01, 8'h00); // ADC 0+1+C
    add(16'd13, 16'h1B01, 16'd14, 8'h01, 8'h01, 8'h00); // SUB
    add(16'd14, 16'h0B01, 16'd15, 8'h00, 8'h01, 8'h00); // SBC, Z sticky-low
    add(16'd15, 16'h1701, 16'd16, 8'h00, 8'h01, 8'h35); // CP no write
    add(16'd16, 16'h0701, 16'd17, 8'h00, 8'h01, 8'h35); // CPC no write
    add(16'd17, 16'h2F01, 16'd18, 8'h01, 8'h01, 8'h35); // MOV
    add(16'd18, 16'h6F00, 16'd19, 8'hF1, 8'h01, 8'h35); // ORI F0
    add(16'd19, 16'h700F, 16'd20, 8'h01, 8'h01, 8'h21); // ANDI 0F
    add(16'd20, 16'h2301, 16'd21, 8'h01, 8'h01, 8'h21); // AND
    add(16'd21, 16'h2B01, 16'd22, 8'h01, 8'h01, 8'h21); // OR
    add(16'd22, 16'hE70F, 16'd23, 8'h7F, 8'h01, 8'h21); // LDI R16,7F
    add(16'd23, 16'h0F01, 16'd24, 8'h80, 8'h01, 8'h2C); // ADD overflow
    add(16'd24, 16'h0000, 16'd25, 8'h80, 8'h01, 8'h2C); // NOP
    add(16'd25, 16'hF411, 16'd28, 8'h80, 8'h01, 8'h2C); // BRNE +2 taken
    add(16'd28, 16'hF028, 16'd29, 8'h80, 8'h01, 8'h2C); // BRCS not taken
    add(16'd29, 16'hC014, 16'd50, 8'h80, 8'h01, 8'h2C); // RJMP +20
    add(16'd50, 16'hCFEB, 16'd30, 8'h80, 8'h01, 8'h2C); // RJMP -21
    add(16'd30, 16'hE3A4, 16'd31, 8'h80, 8'h01, 8'h2C); // LDI R26,34
    add(16'd31, 16'hE1B2, 16'd32, 8'h80, 8'h01, 8'h2C); // LDI R27,12
    add(16'd32, 16'h910C, 16'd33, 8'hA5, 8'h01, 8'h2C); // LD R16,X
    add(16'd33, 16'hE51A, 16'd34, 8'hA5, 8'h5A, 8'h2C); // LDI R17,5A

    for (int i = 0; i < nv; i++) prog[tv[i].pc[7:0]] = tv[i].instr;
    prog[5] = 16'hE505; prog[26] = 16'hE505; prog[27] = 16'hE505; // must be skipped
    prog[34] = 16'h931C; // ST X,R17
    prog[35] = 16'hE000; // LDI R16,0
    prog[36] = 16'h9508; // unsupported

    tick(); tick();
    reset = 1'b0;
    chk("reset_pc", debug_pc, 16'h0000);
    chk("reset_halted", {15'd0, cpu_halted}, 16'd0);
    chk("reset_sreg", {8'd0, status_reg}, 16'h0000);
    chk("reset_dbg_instr", debug_instruction, 16'h0000);
    chk("reset_strobes", {14'd0, data_read, data_write}, 16'd0);

    program_ready = 1'b1;
    for (int i = 0; i < nv; i++) begin
      chk($sformatf("v%0d_pc_pre", i), debug_pc, tv[i].pc);
      sb.push_back(tv[i]);
      tick();
      e = sb.pop_front();
      chk($sformatf("v%0d_pc", i), debug_pc, e.npc);
      chk($sformatf("v%0d_r16", i), {8'd0, debug_reg_r16}, {8'd0, e.r16});
      chk($sformatf("v%0d_r17", i), {8'd0, debug_reg_r17}, {8'd0, e.r17});
      chk($sformatf("v%0d_sreg", i), {8'd0, status_reg}, {8'd0, e.sreg});
      chk($sformatf("v%0d_dbg", i), debug_instruction, e.instr);
    end

    // ST stalled two cycles by data_ready=0
    data_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      chk("st_write", {15'd0, data_write}, 16'd1);
      chk("st_read_low", {15'd0, data_read}, 16'd0);
      chk("st_addr", data_addr, 16'h1234);
      chk("st_data", {8'd0, data_out}, 16'h005A);
      tick();
      chk("st_pc_held", debug_pc, 16'd34);
      chk("st_dbg_held", debug_instruction, 16'hE51A);
    end
    data_ready = 1'b1;
    chk("st_write_final", {15'd0, data_write}, 16'd1);
    tick();
    program_ready = 1'b0;
    #1;
    chk("st_done_pc", debug_pc, 16'd35);
    chk("st_done_dbg", debug_instruction, 16'h931C);
    chk("idle_strobe", {15'd0, data_write}, 16'd0);
    chk("idle_addr", data_addr, 16'h0000);

    // Fetch not ready for three cycles
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("pr0_pc", debug_pc, 16'd35);
      chk("pr0_r16", {8'd0, debug_reg_r16}, 16'h00A5);
    end
    program_ready = 1'b1;
    tick();
    chk("pr1_r16", {8'd0, debug_reg_r16}, 16'h0000);
    chk("pr1_pc", debug_pc, 16'd36);

    // Unsupported opcode -> HALT until reset
    chk("unsup_flag", {15'd0, dut.decoder_inst.unsupported_instruction}, 16'd1);
    chk("unsup_not_halted_yet", {15'd0, cpu_halted}, 16'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("halt_flag", {15'd0, cpu_halted}, 16'd1);
      chk("halt_pc", debug_pc, 16'd36);
      chk("halt_dbg", debug_instruction, 16'hE000);
      chk("halt_r17", {8'd0, debug_reg_r17}, 16'h005A);
    end

    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_pc", debug_pc, 16'h0000);
    chk("rst2_halted", {15'd0, cpu_halted}, 16'd0);
    chk("rst2_r17", {8'd0, debug_reg_r17}, 16'h0000);
    chk("rst2_sreg", {8'd0, status_reg}, 16'h0000);
    chk("rst2_dbg", debug_instruction, 16'h0000);
    tick();
    chk("rst2_runs", {8'd0, debug_reg_r16}, 16'h0005);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
